// File: rtl/xilinx_1w1r_sram_fwd_pkg.sv
// Shared camera/CNN memory definitions: default geometry, legal read latencies,
// collision policy encoding and small elaboration-time helpers.
package xilinx_1w1r_sram_fwd_pkg;

    localparam int unsigned DEF_WWORD  = 32;
    localparam int unsigned DEF_WP     = 8;
    localparam int unsigned DEF_WADDR  = 5;
    localparam int unsigned DEF_DEPTH  = 24;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    typedef enum logic {
        COLL_READ_FIRST  = 1'b0,
        COLL_WRITE_FIRST = 1'b1
    } coll_mode_e;

    function automatic int unsigned lane_count(input int unsigned wword, input int unsigned wp);
        return wword / wp;
    endfunction

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/xilinx_1w1r_sram_fwd_if.sv
// Port bundle of the 1w1r SRAM: read port (aa/cena/qa), write port
// (ab/db/wenb/cenb) and status pulses.
interface xilinx_1w1r_sram_fwd_if
    import xilinx_1w1r_sram_fwd_pkg::*;
#(
    parameter int unsigned WWORD = DEF_WWORD,
    parameter int unsigned WADDR = DEF_WADDR,
    parameter int unsigned WP    = DEF_WP
);

    logic [WWORD-1:0]    qa;
    logic                qa_vld;
    logic [WADDR-1:0]    aa;
    logic                cena;
    logic [WWORD-1:0]    db;
    logic [WADDR-1:0]    ab;
    logic [WWORD/WP-1:0] wenb;
    logic                cenb;
    logic                oor_err;

    modport master (
        output aa, cena, db, ab, wenb, cenb,
        input  qa, qa_vld, oor_err
    );

    modport slave (
        input  aa, cena, db, ab, wenb, cenb,
        output qa, qa_vld, oor_err
    );

endinterface

// File: rtl/xilinx_1w1r_sram_fwd_core.sv
// Plain 1w1r array: lane-masked write and registered read-first output, kept
// free of reset and bypass logic so it maps onto BRAM/LUTRAM.
module sram_1w1r_core
    import xilinx_1w1r_sram_fwd_pkg::*;
#(
    parameter int unsigned WWORD = DEF_WWORD,
    parameter int unsigned WADDR = DEF_WADDR,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WP    = DEF_WP
) (
    input  logic                clk,
    input  logic                i_re,
    input  logic [WADDR-1:0]    i_ra,
    output logic [WWORD-1:0]    o_rd,
    input  logic                i_we,
    input  logic [WADDR-1:0]    i_wa,
    input  logic [WWORD-1:0]    i_wd,
    input  logic [WWORD/WP-1:0] i_lane_we
);

    localparam int unsigned NL = lane_count(WWORD, WP);

    logic [WWORD-1:0] r_mem [DEPTH];
    logic [WWORD-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < NL; i++) begin
                if (i_lane_we[i]) begin
                    r_mem[i_wa][i*WP +: WP] <= i_wd[i*WP +: WP];
                end
            end
        end
        if (i_re) begin
            r_rd <= r_mem[i_ra];
        end
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/xilinx_1w1r_sram_fwd.sv
// Single-clock 1w1r SRAM with per-lane write enables, same-cycle collision
// forwarding, selectable read latency, read-valid and out-of-range reporting.
module xilinx_1w1r_sram_fwd
    import xilinx_1w1r_sram_fwd_pkg::*;
#(
    parameter int unsigned WWORD  = DEF_WWORD,
    parameter int unsigned WADDR  = DEF_WADDR,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned WP     = DEF_WP,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    xilinx_1w1r_sram_fwd_if.slave  bus
);

    localparam int unsigned        NL        = lane_count(WWORD, WP);
    localparam coll_mode_e         COLL_MODE = (BYPASS != 0) ? COLL_WRITE_FIRST : COLL_READ_FIRST;
    localparam logic [WADDR:0]     LIMIT     = (WADDR+1)'(DEPTH);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("xilinx_1w1r_sram_fwd: RD_LAT must be 1 or 2");
    end
    if ((WP == 0) || (WWORD % WP != 0)) begin : g_bad_lane
        $error("xilinx_1w1r_sram_fwd: WWORD must be a non-zero multiple of WP");
    end
    if ((DEPTH == 0) || (64'(DEPTH) > (64'd1 << WADDR))) begin : g_bad_depth
        $error("xilinx_1w1r_sram_fwd: DEPTH must be in 1..2**WADDR");
    end

    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_rd_oor;
    logic             w_wr_oor;
    logic             w_core_re;
    logic             w_core_we;
    logic             w_coll;
    logic [NL-1:0]    w_lane_we;
    logic [WWORD-1:0] w_fwd_mask;
    logic [WWORD-1:0] w_core_rd;
    logic [WWORD-1:0] w_merged;
    logic             w_out_vld;
    logic [WWORD-1:0] w_out_data;

    logic             r_s1_vld;
    logic             r_s1_oor;
    logic [WWORD-1:0] r_s1_mask;
    logic [WWORD-1:0] r_s1_fwd;
    logic             r_oor_pend;
    logic [WWORD-1:0] r_qa;
    logic             r_qa_vld;
    logic             r_oor_err;

    // Requests are dropped while in reset; out-of-range accesses never reach the array.
    always_comb begin
        w_rd_req   = !rst && !bus.cena;
        w_wr_req   = !rst && !bus.cenb;
        w_rd_oor   = w_rd_req && ({1'b0, bus.aa} >= LIMIT);
        w_wr_oor   = w_wr_req && ({1'b0, bus.ab} >= LIMIT);
        w_core_re  = w_rd_req && !w_rd_oor;
        w_core_we  = w_wr_req && !w_wr_oor;
        w_lane_we  = ~bus.wenb;
        w_coll     = w_core_re && w_core_we && (bus.aa == bus.ab)
                     && (COLL_MODE == COLL_WRITE_FIRST);
        w_fwd_mask = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (w_coll && w_lane_we[i]) begin
                w_fwd_mask[i*WP +: WP] = '1;
            end
        end
    end

    sram_1w1r_core #(
        .WWORD (WWORD),
        .WADDR (WADDR),
        .DEPTH (DEPTH),
        .WP    (WP)
    ) u_core (
        .clk       (clk),
        .i_re      (w_core_re),
        .i_ra      (bus.aa),
        .o_rd      (w_core_rd),
        .i_we      (w_core_we),
        .i_wa      (bus.ab),
        .i_wd      (bus.db),
        .i_lane_we (w_lane_we)
    );

    // Stage 1 runs alongside the array read: it carries the forward mask/data so the
    // merge happens on the registered array output instead of in front of the BRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_oor   <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_fwd   <= '0;
            r_oor_pend <= 1'b0;
        end else begin
            r_s1_vld   <= w_rd_req;
            r_oor_pend <= w_rd_oor || w_wr_oor;
            if (w_rd_req) begin
                r_s1_oor  <= w_rd_oor;
                r_s1_mask <= w_fwd_mask;
                r_s1_fwd  <= bus.db;
            end
        end
    end

    assign w_merged = r_s1_oor ? '0 : ((w_core_rd & ~r_s1_mask) | (r_s1_fwd & r_s1_mask));

    if (RD_LAT == 2) begin : g_lat2
        logic             r_s2_vld;
        logic [WWORD-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_vld  <= 1'b0;
                r_s2_data <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_data <= w_merged;
                end
            end
        end

        assign w_out_vld  = r_s2_vld;
        assign w_out_data = r_s2_data;
    end else begin : g_lat1
        assign w_out_vld  = r_s1_vld;
        assign w_out_data = w_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qa      <= '0;
            r_qa_vld  <= 1'b0;
            r_oor_err <= 1'b0;
        end else begin
            r_qa_vld  <= w_out_vld;
            r_oor_err <= r_oor_pend;
            if (w_out_vld) begin
                r_qa <= w_out_data;
            end
        end
    end

    assign bus.qa      = r_qa;
    assign bus.qa_vld  = r_qa_vld;
    assign bus.oor_err = r_oor_err;

endmodule

// File: tb/tb_xilinx_1w1r_sram_fwd.sv
// Scoreboard bench: three instances (lat1/write-first, lat1/read-first,
// lat2/write-first) share one directed stimulus; per-instance monitors pop expectations.
module tb_xilinx_1w1r_sram_fwd;

    localparam int unsigned WWORD = 32;
    localparam int unsigned WADDR = 5;
    localparam int unsigned DEPTH = 24;
    localparam int unsigned WP    = 8;
    localparam int unsigned NDUT  = 3;
    localparam int unsigned LAT [NDUT] = '{1, 1, 2};
    localparam int unsigned BYP [NDUT] = '{1, 0, 1};

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } rd_exp_t;

    rd_exp_t     rdq  [NDUT][$];
    int unsigned oorq [NDUT][$];

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        s_cena, s_cenb;
    logic [4:0]  s_aa, s_ab;
    logic [31:0] s_db;
    logic [3:0]  s_wenb;

    logic [31:0] o_qa  [NDUT];
    logic        o_vld [NDUT];
    logic        o_oor [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        xilinx_1w1r_sram_fwd_if #(.WWORD(WWORD), .WADDR(WADDR), .WP(WP)) bus ();

        assign bus.aa   = s_aa;
        assign bus.cena = s_cena;
        assign bus.ab   = s_ab;
        assign bus.cenb = s_cenb;
        assign bus.db   = s_db;
        assign bus.wenb = s_wenb;
        assign o_qa[g]  = bus.qa;
        assign o_vld[g] = bus.qa_vld;
        assign o_oor[g] = bus.oor_err;

        xilinx_1w1r_sram_fwd #(
            .WWORD  (WWORD),
            .WADDR  (WADDR),
            .DEPTH  (DEPTH),
            .WP     (WP),
            .RD_LAT (LAT[g]),
            .BYPASS (BYP[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        always @(negedge clk) begin : mon
            rd_exp_t e;
            logic    due;
            logic    due_o;
            due = (rdq[g].size() != 0) && (rdq[g][0].cyc == cyc);
            if (o_vld[g] || due) begin
                check($sformatf("dut%0d qa_vld", g), 32'(o_vld[g]), 32'(due));
                if (rdq[g].size() != 0) begin
                    e = rdq[g].pop_front();
                    if (o_vld[g]) check($sformatf("dut%0d qa", g), o_qa[g], e.data);
                end
            end
            due_o = (oorq[g].size() != 0) && (oorq[g][0] == cyc);
            if (o_oor[g] || due_o) begin
                check($sformatf("dut%0d oor_err", g), 32'(o_oor[g]), 32'(due_o));
                if (oorq[g].size() != 0) void'(oorq[g].pop_front());
            end
        end
    end

    function automatic logic [31:0] fill_word(input int unsigned a);
        return {8'hA5, 8'(a), 8'h5A, 8'(a)};
    endfunction

    task automatic drive(input logic rd, input logic [4:0] ra, input logic wr,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] wenb);
        @(negedge clk);
        s_cena = ~rd;
        s_aa   = ra;
        s_cenb = ~wr;
        s_ab   = wa;
        s_db   = wd;
        s_wenb = wenb;
    endtask

    task automatic expect_rd(input logic [31:0] wf, input logic [31:0] rf);
        for (int g = 0; g < NDUT; g++)
            rdq[g].push_back('{data: (BYP[g] != 0) ? wf : rf, cyc: cyc + 1 + LAT[g]});
    endtask

    task automatic expect_oor();
        for (int g = 0; g < NDUT; g++) oorq[g].push_back(cyc + 2);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] wenb);
        drive(1'b0, 5'd0, 1'b1, a, d, wenb);
        if (a >= DEPTH) expect_oor();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        drive(1'b1, a, 1'b0, 5'd0, 32'd0, 4'hF);
        expect_rd(exp, exp);
        if (a >= DEPTH) expect_oor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 4'hF);
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s dut%0d qa", tag, g), o_qa[g], 32'd0);
            check($sformatf("%s dut%0d qa_vld", tag, g), 32'(o_vld[g]), 32'd0);
            check($sformatf("%s dut%0d oor_err", tag, g), 32'(o_oor[g]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_cena = 1'b1; s_cenb = 1'b1; s_aa = '0; s_ab = '0; s_db = '0; s_wenb = '1;
        // A read presented during reset must be ignored (monitors flag any qa_vld).
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 4'hF);
        idle(2);
        check_reset_state("reset");
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) wr(5'(a), fill_word(a), 4'b0000);
        for (int a = 0; a < DEPTH; a++) rd(5'(a), fill_word(a));

        wr(5'd3, 32'hDEADBEEF, 4'b0000);
        rd(5'd3, 32'hDEADBEEF);

        wr(5'd5, 32'h11223344, 4'b0000);
        wr(5'd5, 32'hAABBCCDD, 4'b1010);
        rd(5'd5, 32'h11BB33DD);

        // Collision: lanes 1 and 2 enabled (active-low wenb).
        wr(5'd7, 32'h01020304, 4'b0000);
        drive(1'b1, 5'd7, 1'b1, 5'd7, 32'hF0F0F0F0, 4'b1001);
        expect_rd(32'h01F0F004, 32'h01020304);
        rd(5'd7, 32'h01F0F004);

        wr(5'd30, 32'hFFFFFFFF, 4'b0000);
        rd(5'd30, 32'd0);
        rd(5'd6, fill_word(6));
        rd(5'd23, fill_word(23));
        rd(5'd24, 32'd0);
        wr(5'd24, 32'h12345678, 4'b0000);
        drive(1'b1, 5'd31, 1'b1, 5'd30, 32'hFFFFFFFF, 4'b0000);
        expect_rd(32'd0, 32'd0);
        expect_oor();
        drive(1'b1, 5'd30, 1'b1, 5'd30, 32'hFFFFFFFF, 4'b0000);
        expect_rd(32'd0, 32'd0);
        expect_oor();
        rd(5'd6, fill_word(6));
        rd(5'd0, fill_word(0));

        // Write one cycle after a read of the same word must not alter that read.
        rd(5'd9, fill_word(9));
        wr(5'd9, 32'h99999999, 4'b0000);
        rd(5'd9, 32'h99999999);
        idle(3);

        // Reset on the edge after a read: the read is dropped, memory survives.
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        s_cena = 1'b1;
        idle(1);
        check_reset_state("midread");
        idle(1);
        rst = 1'b0;
        rd(5'd3, 32'hDEADBEEF);
        rd(5'd5, 32'h11BB33DD);
        idle(6);

        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("dut%0d pending reads", g), 32'(rdq[g].size()), 32'd0);
            check($sformatf("dut%0d pending oor", g), 32'(oorq[g].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
